seg7_scan: RTL

Time-multiplexed scan controller for a DIGITS-digit common-anode 7-segment display. A single `b27s` hex-to-segment decoder is shared across all digits. The block double-buffers the displayed value, applies updates only at frame boundaries (no tearing), and inserts dead time between digits to suppress ghosting. It sits between the register/switch logic that produces a 16-bit value and the board's segment and anode pins.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/b27s.sv | 30 +++
 rtl/seg7_scan.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, constants and elaboration-time helpers for the
// 7-segment scan controller.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Ceiling log2, used only on parameters at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/b27s.sv
// b27s: hex nibble to active-high 7-segment pattern, bit0=a .. bit6=g.
module b27s (
  input  logic [3:0] sw,
  output logic [6:0] led
);

  always_comb begin
    led = 7'b0000000;
    case (sw)
      4'h0: led = 7'b0111111;
      4'h1: led = 7'b0000110;
      4'h2: led = 7'b1011011;
      4'h3: led = 7'b1001111;
      4'h4: led = 7'b1100110;
      4'h5: led = 7'b1101101;
      4'h6: led = 7'b1111101;
      4'h7: led = 7'b0000111;
      4'h8: led = 7'b1111111;
      4'h9: led = 7'b1101111;
      4'hA: led = 7'b1110111;
      4'hB: led = 7'b1111100;
      4'hC: led = 7'b0111001;
      4'hD: led = 7'b1011110;
      4'hE: led = 7'b1111011;
      4'hF: led = 7'b1110001;
      default: led = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed common-anode display driver with a shared
// decoder, frame-synchronous double buffering and dead time between digits.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DWELL  = 50000,
  parameter int DEAD   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [6:0]            led,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_start,
  output logic                  upd_pending
);

  localparam int CNT_RAW = clog2(max2(DWELL, DEAD));
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam int IDX_RAW = clog2(DIGITS);
  localparam int IDX_W   = (IDX_RAW < 1) ? 1 : IDX_RAW;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_idx, w_idx_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_run, w_run_next;
  logic               w_frame_edge;
  logic               w_sync;

  logic [4*DIGITS-1:0] r_act_data, w_act_data_next;
  logic [4*DIGITS-1:0] r_pend_data, w_pend_data_next;
  logic [DIGITS-1:0]   r_act_blank, w_act_blank_next;
  logic [DIGITS-1:0]   r_pend_blank, w_pend_blank_next;
  logic                r_pend, w_pend_next;

  logic [3:0]          w_nibble [DIGITS];
  logic [3:0]          w_sel;
  logic [6:0]          w_dec;
  logic [6:0]          w_led_next, r_led;
  logic [DIGITS-1:0]   w_an_n_next, r_an_n;
  logic                r_frame_start;

  // r_run distinguishes "idle" from "first BLANK cycle of d0" so that the
  // first enabled edge lands on cnt 0 with a frame_start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= BLANK;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
      r_run   <= w_run_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt + 1'b1;
    w_run_next   = 1'b1;
    w_frame_edge = 1'b0;
    if (!en) begin
      w_state_next = BLANK;
      w_idx_next   = '0;
      w_cnt_next   = '0;
      w_run_next   = 1'b0;
    end else if (!r_run) begin
      w_state_next = BLANK;
      w_idx_next   = '0;
      w_cnt_next   = '0;
      w_frame_edge = 1'b1;
    end else if (r_state == BLANK) begin
      if (r_cnt == DEAD_LAST) begin
        w_state_next = SHOW;
        w_cnt_next   = '0;
      end
    end else if (r_cnt == DWELL_LAST) begin
      w_state_next = BLANK;
      w_cnt_next   = '0;
      if (r_idx == IDX_LAST) begin
        w_idx_next   = '0;
        w_frame_edge = 1'b1;
      end else begin
        w_idx_next = r_idx + 1'b1;
      end
    end
  end

  // Buffer swap: a load on a sync edge bypasses pend and wins over it.
  assign w_sync = !en || w_frame_edge;

  always_comb begin
    w_act_data_next   = r_act_data;
    w_act_blank_next  = r_act_blank;
    w_pend_data_next  = r_pend_data;
    w_pend_blank_next = r_pend_blank;
    w_pend_next       = r_pend;
    if (w_sync) begin
      if (load) begin
        w_act_data_next  = data_in;
        w_act_blank_next = blank_in;
      end else if (r_pend) begin
        w_act_data_next  = r_pend_data;
        w_act_blank_next = r_pend_blank;
      end
      w_pend_next = 1'b0;
    end else if (load) begin
      w_pend_data_next  = data_in;
      w_pend_blank_next = blank_in;
      w_pend_next       = 1'b1;
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
    assign w_nibble[gi] = w_act_data_next[4*gi +: 4];
  end

  assign w_sel = w_nibble[w_idx_next];

  b27s u_dec (
    .sw  (w_sel),
    .led (w_dec)
  );

  // Outputs are computed from the next state so the registered pins line
  // up with the state they describe, without an extra cycle of lag.
  always_comb begin
    w_led_next  = SEG_BLANK;
    w_an_n_next = '1;
    if (w_state_next == SHOW && !w_act_blank_next[w_idx_next]) begin
      w_led_next              = w_dec;
      w_an_n_next[w_idx_next] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_act_data    <= '0;
      r_act_blank   <= '1;
      r_pend_data   <= '0;
      r_pend_blank  <= '0;
      r_pend        <= 1'b0;
      r_led         <= SEG_BLANK;
      r_an_n        <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_act_data    <= w_act_data_next;
      r_act_blank   <= w_act_blank_next;
      r_pend_data   <= w_pend_data_next;
      r_pend_blank  <= w_pend_blank_next;
      r_pend        <= w_pend_next;
      r_led         <= w_led_next;
      r_an_n        <= w_an_n_next;
      r_frame_start <= w_frame_edge;
    end
  end

  assign led         = r_led;
  assign an_n        = r_an_n;
  assign frame_start = r_frame_start;
  assign upd_pending = r_pend;

endmodule
